// File: rtl/text_page_ctrl_pkg.sv
// Shared constants and FSM encoding for the text page controller.
package text_pkg;

    localparam int unsigned COLS = 31;
    localparam int unsigned ROWS = 20;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] FF    = 8'h0C;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        CLEAR       = 3'd1,
        SCROLL_RD   = 3'd2,
        SCROLL_WR   = 3'd3,
        SCROLL_LAST = 3'd4
    } state_e;

endpackage

// File: rtl/text_row_ram.sv
// Single-port row memory: byte-lane or full-row writes, registered 1-cycle read.
module text_row_ram #(
    parameter int unsigned COLS = 31,
    parameter int unsigned ROWS = 20
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic              i_we_row,
    input  logic [COLS-1:0]   i_be,
    input  logic [4:0]        i_addr,
    input  logic [COLS*8-1:0] i_wdata,
    output logic [COLS*8-1:0] o_rdata
);

    logic [COLS*8-1:0] r_mem [ROWS];
    logic [COLS*8-1:0] r_rdata;
    logic              w_addr_ok;

    assign w_addr_ok = (32'(i_addr) < ROWS);
    assign o_rdata   = r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en && w_addr_ok) begin
            if (i_we || i_we_row) begin
                for (int i = 0; i < int'(COLS); i++) begin
                    if (i_we_row || i_be[i]) begin
                        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

endmodule

// File: rtl/text_page_ctrl.sv
// Character page owner: writer handshake, cursor, clear/scroll FSM and a
// renderer-priority mux onto the single-port row memory.
module text_page_ctrl #(
    parameter int unsigned COLS = text_pkg::COLS,
    parameter int unsigned ROWS = text_pkg::ROWS
) (
    input  logic              VGA_CLK_IN,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [7:0]        wr_char,
    output logic              wr_ready,
    input  logic              rd_req,
    input  logic [4:0]        rd_row,
    output logic              rd_valid,
    output logic [COLS*8-1:0] rd_line,
    output logic [4:0]        cur_row,
    output logic [4:0]        cur_col,
    output logic              busy
);
    import text_pkg::*;

    localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);
    localparam logic [4:0]        PEN_ROW  = 5'(ROWS - 2);
    localparam logic [4:0]        LAST_COL = 5'(COLS - 1);
    localparam logic [COLS*8-1:0] SPACES   = {COLS{SPACE}};
    localparam logic [COLS-1:0]   MSB_LANE = {1'b1, {(COLS-1){1'b0}}};

    state_e            r_state, w_state_nxt;
    logic [4:0]        r_r, w_r_nxt;
    logic [4:0]        r_cur_row, w_row_nxt;
    logic [4:0]        r_cur_col, w_col_nxt;
    logic              r_rd_valid, r_rd_oob;
    logic [COLS*8-1:0] r_rd_line, r_sbuf;
    logic              r_sbuf_fresh;

    logic              w_en, w_we, w_we_row, w_adv, w_rd_oob;
    logic [COLS-1:0]   w_be;
    logic [4:0]        w_addr;
    logic [COLS*8-1:0] w_wdata, w_ram_q, w_line, w_scroll_data;

    assign w_rd_oob      = (rd_row >= 5'(ROWS));
    // Scroll data arrives one cycle after SCROLL_RD; bypass it until latched,
    // since a stalling renderer read would overwrite the RAM output register.
    assign w_scroll_data = r_sbuf_fresh ? w_ram_q : r_sbuf;
    assign w_line        = r_rd_valid ? (r_rd_oob ? SPACES : w_ram_q) : r_rd_line;

    assign wr_ready = (r_state == IDLE) && !rd_req;
    assign busy     = (r_state != IDLE);
    assign rd_valid = r_rd_valid;
    assign rd_line  = w_line;
    assign cur_row  = r_cur_row;
    assign cur_col  = r_cur_col;

    always_comb begin
        w_state_nxt = r_state;
        w_r_nxt     = r_r;
        w_row_nxt   = r_cur_row;
        w_col_nxt   = r_cur_col;
        w_en        = 1'b0;
        w_we        = 1'b0;
        w_we_row    = 1'b0;
        w_be        = '0;
        w_addr      = r_r;
        w_wdata     = SPACES;
        w_adv       = 1'b0;
        if (rd_req) begin
            w_en   = !w_rd_oob;
            w_addr = rd_row;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (wr_valid) begin
                        if (wr_char >= 8'h20 && wr_char <= 8'h7E) begin
                            w_en    = 1'b1;
                            w_we    = 1'b1;
                            w_addr  = r_cur_row;
                            w_be    = MSB_LANE >> r_cur_col;
                            w_wdata = {COLS{wr_char}};
                            if (r_cur_col == LAST_COL) begin
                                w_col_nxt = '0;
                                w_adv     = 1'b1;
                            end else begin
                                w_col_nxt = r_cur_col + 5'd1;
                            end
                        end else if (wr_char == LF) begin
                            w_col_nxt = '0;
                            w_adv     = 1'b1;
                        end else if (wr_char == BS) begin
                            if (r_cur_col != '0) begin
                                w_col_nxt = r_cur_col - 5'd1;
                                w_en      = 1'b1;
                                w_we      = 1'b1;
                                w_addr    = r_cur_row;
                                w_be      = MSB_LANE >> (r_cur_col - 5'd1);
                            end
                        end else if (wr_char == FF) begin
                            w_row_nxt   = '0;
                            w_col_nxt   = '0;
                            w_r_nxt     = '0;
                            w_state_nxt = CLEAR;
                        end
                        if (w_adv) begin
                            if (r_cur_row < LAST_ROW) begin
                                w_row_nxt = r_cur_row + 5'd1;
                            end else begin
                                w_r_nxt     = '0;
                                w_state_nxt = SCROLL_RD;
                            end
                        end
                    end
                end
                CLEAR: begin
                    w_en     = 1'b1;
                    w_we_row = 1'b1;
                    if (r_r == LAST_ROW) begin
                        w_r_nxt     = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_r_nxt = r_r + 5'd1;
                    end
                end
                SCROLL_RD: begin
                    w_en        = 1'b1;
                    w_addr      = r_r + 5'd1;
                    w_state_nxt = SCROLL_WR;
                end
                SCROLL_WR: begin
                    w_en     = 1'b1;
                    w_we_row = 1'b1;
                    w_wdata  = w_scroll_data;
                    if (r_r == PEN_ROW) begin
                        w_state_nxt = SCROLL_LAST;
                    end else begin
                        w_r_nxt     = r_r + 5'd1;
                        w_state_nxt = SCROLL_RD;
                    end
                end
                SCROLL_LAST: begin
                    w_en        = 1'b1;
                    w_we_row    = 1'b1;
                    w_addr      = LAST_ROW;
                    w_r_nxt     = '0;
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_r_nxt     = '0;
                    w_state_nxt = CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge VGA_CLK_IN) begin
        if (!rst_n) begin
            r_state      <= CLEAR;
            r_r          <= '0;
            r_cur_row    <= '0;
            r_cur_col    <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_oob     <= 1'b0;
            r_rd_line    <= '0;
            r_sbuf       <= '0;
            r_sbuf_fresh <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_r          <= w_r_nxt;
            r_cur_row    <= w_row_nxt;
            r_cur_col    <= w_col_nxt;
            r_rd_valid   <= rd_req;
            r_rd_oob     <= w_rd_oob;
            r_sbuf_fresh <= (r_state == SCROLL_RD) && !rd_req;
            if (r_rd_valid) begin
                r_rd_line <= w_line;
            end
            if (r_sbuf_fresh) begin
                r_sbuf <= w_ram_q;
            end
        end
    end

    text_row_ram #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_ram (
        .i_clk    (VGA_CLK_IN),
        .i_en     (w_en),
        .i_we     (w_we),
        .i_we_row (w_we_row),
        .i_be     (w_be),
        .i_addr   (w_addr),
        .i_wdata  (w_wdata),
        .o_rdata  (w_ram_q)
    );

endmodule
